// File: rtl/ex1_pkg.sv
// rtl/ex1_pkg.sv - shared types and constants for the ex1 scheduler
// Purpose: FSM state encoding, latency-counter width and requester index type
//          shared by ex1_sched and ex1_rr_arb.
// Ports: none (package).
package ex1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the largest legal EX1_LAT (15).
  localparam int LAT_CNT_W = $clog2(16);

  typedef logic req_idx_t;

endpackage

// File: rtl/ex1_rr_arb.sv
// rtl/ex1_rr_arb.sv - two-input round-robin arbiter, purely combinational
// Purpose: picks one of two requesters; the pointer register lives in the caller.
// Ports:
//   valid   in  [1:0] request valids
//   rr      in  1     round-robin pointer, winner when both are valid
//   en      in  1     arbitration enable (no grant when low)
//   grant   out [1:0] one-hot grant
//   gnt_idx out 1     index of the granted requester (meaningful only with a grant)
module ex1_rr_arb
  import ex1_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   rr,
  input  logic       en,
  output logic [1:0] grant,
  output req_idx_t   gnt_idx
);

  always_comb begin
    grant   = 2'b00;
    gnt_idx = rr;
    if (en) begin
      if (valid == 2'b11) begin
        gnt_idx = rr;
        grant   = rr ? 2'b10 : 2'b01;
      end else if (valid[0]) begin
        gnt_idx = 1'b0;
        grant   = 2'b01;
      end else if (valid[1]) begin
        gnt_idx = 1'b1;
        grant   = 2'b10;
      end
    end
  end

endmodule

// File: rtl/ex1_sched.sv
// rtl/ex1_sched.sv - round-robin scheduler sharing one ex1_block between two requesters
// Purpose: accepts one (A,B) pair at a time, drives it to the external ex1_block,
//          waits EX1_LAT cycles, captures (C,D) and returns it to the owner.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   reqN_valid/reqN_a/reqN_b       operand offer from requester N
//   reqN_ready                     combinational grant (IDLE only)
//   rspN_valid/rspN_c/rspN_d       registered result for requester N
//   rspN_ready                     requester N takes the result
//   ex_a, ex_b                     registered operands to ex1_block
//   ex_c, ex_d                     results from ex1_block
//   busy                           high outside IDLE
//   done_cnt                       completed responses, wraps
module ex1_sched
  import ex1_pkg::*;
#(
  parameter int EX1_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_a,
  input  logic             req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_a,
  input  logic             req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp0_c,
  output logic             rsp0_d,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic             rsp1_c,
  output logic             rsp1_d,
  input  logic             rsp1_ready,
  output logic             ex_a,
  output logic             ex_b,
  input  logic             ex_c,
  input  logic             ex_d,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(EX1_LAT);

  state_t                 r_state;
  req_idx_t               r_rr;
  req_idx_t               r_owner;
  logic [LAT_CNT_W-1:0]   r_cnt;
  logic                   r_ex_a, r_ex_b;
  logic                   r_rsp0_valid, r_rsp0_c, r_rsp0_d;
  logic                   r_rsp1_valid, r_rsp1_c, r_rsp1_d;
  logic [CNT_W-1:0]       r_done_cnt;

  logic [1:0]             w_grant;
  req_idx_t               w_gnt_idx;
  logic                   w_accept;
  logic                   w_rsp_take;

  ex1_rr_arb u_arb (
    .valid   ({req1_valid, req0_valid}),
    .rr      (r_rr),
    .en      (r_state == IDLE),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx)
  );

  // A grant is only ever issued to a valid requester, so a grant is an accept.
  assign w_accept   = |w_grant;
  // Only the owner's ready can retire the response.
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rr         <= 1'b0;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_ex_a       <= 1'b0;
      r_ex_b       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_c     <= 1'b0;
      r_rsp0_d     <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_c     <= 1'b0;
      r_rsp1_d     <= 1'b0;
      r_done_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_gnt_idx;
            r_ex_a  <= w_gnt_idx ? req1_a : req0_a;
            r_ex_b  <= w_gnt_idx ? req1_b : req0_b;
            r_cnt   <= LAT_INIT;
            r_rr    <= ~w_gnt_idx;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // The counter hits zero EX1_LAT edges after the accept, so the
          // capture edge is accept + 1 + EX1_LAT.
          if (r_cnt == '0) begin
            if (r_owner) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_c     <= ex_c;
              r_rsp1_d     <= ex_d;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_c     <= ex_c;
              r_rsp0_d     <= ex_d;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_done_cnt   <= r_done_cnt + CNT_W'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_c     = r_rsp0_c;
  assign rsp0_d     = r_rsp0_d;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_c     = r_rsp1_c;
  assign rsp1_d     = r_rsp1_d;
  assign ex_a       = r_ex_a;
  assign ex_b       = r_ex_b;
  assign busy       = (r_state != IDLE);
  assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_ex1_sched.sv
// tb/tb_ex1_sched.sv - scoreboard bench for ex1_sched at two parameter sets
module tb_ex1_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: EX1_LAT=1, CNT_W=8
  logic a_req0_valid, a_req0_a, a_req0_b, a_req0_ready;
  logic a_req1_valid, a_req1_a, a_req1_b, a_req1_ready;
  logic a_rsp0_valid, a_rsp0_c, a_rsp0_d, a_rsp0_ready;
  logic a_rsp1_valid, a_rsp1_c, a_rsp1_d, a_rsp1_ready;
  logic a_ex_a, a_ex_b, a_ex_c, a_ex_d, a_busy;
  logic [7:0] a_done_cnt;
  logic [1:0] a_pipe;

  // Instance B: EX1_LAT=3, CNT_W=2
  logic b_req0_valid, b_req0_a, b_req0_b, b_req0_ready;
  logic b_req1_valid, b_req1_a, b_req1_b, b_req1_ready;
  logic b_rsp0_valid, b_rsp0_c, b_rsp0_d, b_rsp0_ready;
  logic b_rsp1_valid, b_rsp1_c, b_rsp1_d, b_rsp1_ready;
  logic b_ex_a, b_ex_b, b_ex_c, b_ex_d, b_busy;
  logic [1:0] b_done_cnt;
  logic [1:0] b_pipe0, b_pipe1, b_pipe2;

  ex1_sched #(.EX1_LAT(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_a(a_req0_a), .req0_b(a_req0_b), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_a(a_req1_a), .req1_b(a_req1_b), .req1_ready(a_req1_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_c(a_rsp0_c), .rsp0_d(a_rsp0_d), .rsp0_ready(a_rsp0_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_c(a_rsp1_c), .rsp1_d(a_rsp1_d), .rsp1_ready(a_rsp1_ready),
    .ex_a(a_ex_a), .ex_b(a_ex_b), .ex_c(a_ex_c), .ex_d(a_ex_d),
    .busy(a_busy), .done_cnt(a_done_cnt)
  );

  ex1_sched #(.EX1_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_ready(b_req1_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_c(b_rsp0_c), .rsp0_d(b_rsp0_d), .rsp0_ready(b_rsp0_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_c(b_rsp1_c), .rsp1_d(b_rsp1_d), .rsp1_ready(b_rsp1_ready),
    .ex_a(b_ex_a), .ex_b(b_ex_b), .ex_c(b_ex_c), .ex_d(b_ex_d),
    .busy(b_busy), .done_cnt(b_done_cnt)
  );

  // Stand-in ex1_block: C = A xor B, D = A and B, delayed by EX1_LAT registers.
  always @(posedge clk or negedge rst)
    if (!rst) a_pipe <= 2'b00;
    else      a_pipe <= {a_ex_a ^ a_ex_b, a_ex_a & a_ex_b};
  assign a_ex_c = a_pipe[1];
  assign a_ex_d = a_pipe[0];

  always @(posedge clk or negedge rst)
    if (!rst) begin
      b_pipe0 <= 2'b00; b_pipe1 <= 2'b00; b_pipe2 <= 2'b00;
    end else begin
      b_pipe0 <= {b_ex_a ^ b_ex_b, b_ex_a & b_ex_b};
      b_pipe1 <= b_pipe0;
      b_pipe2 <= b_pipe1;
    end
  assign b_ex_c = b_pipe2[1];
  assign b_ex_d = b_pipe2[0];

  int n_chk = 0;
  int n_pass = 0;

  task automatic note_fail(input string name, input int act, input int exp);
    n_chk++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act == exp) begin
      n_chk++;
      n_pass++;
    end else begin
      note_fail(name, act, exp);
    end
  endtask

  // Scoreboard queues: expected grant order and expected {c,d} per owner.
  int exp_gnt[$];
  int q0[$];
  int q1[$];
  int bq0[$];
  int acc_cyc[$];
  int n_acc = 0;
  int last_gnt = 0;

  task automatic on_accept(input int idx);
    if (exp_gnt.size() == 0) note_fail("grant_unexpected", idx, -1);
    else chk("grant_order", idx, exp_gnt.pop_front());
    last_gnt = idx;
    n_acc++;
    acc_cyc.push_back(cyc);
  endtask

  task automatic on_rsp(input int idx, input int cd);
    chk("rsp_owner", idx, last_gnt);
    if (idx == 0) begin
      if (q0.size() == 0) note_fail("rsp0_unexpected", cd, -1);
      else chk("rsp0_data", cd, q0.pop_front());
    end else begin
      if (q1.size() == 0) note_fail("rsp1_unexpected", cd, -1);
      else chk("rsp1_data", cd, q1.pop_front());
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (a_req0_valid && a_req0_ready) on_accept(0);
      if (a_req1_valid && a_req1_ready) on_accept(1);
      if (a_req0_ready && a_req1_ready) note_fail("a_double_ready", 2, 1);
      if (a_rsp0_valid && a_rsp0_ready) on_rsp(0, {a_rsp0_c, a_rsp0_d});
      if (a_rsp1_valid && a_rsp1_ready) on_rsp(1, {a_rsp1_c, a_rsp1_d});
      if (b_rsp0_valid && b_rsp0_ready) begin
        if (bq0.size() == 0) note_fail("b_rsp0_unexpected", {b_rsp0_c, b_rsp0_d}, -1);
        else chk("b_rsp0_data", {b_rsp0_c, b_rsp0_d}, bq0.pop_front());
      end
      if (b_rsp1_valid) note_fail("b_rsp1_unexpected", 1, 0);
    end
  end

  task automatic issue_a(input bit idx, input bit a, input bit b);
    int n;
    @(posedge clk); #1;
    if (idx) begin a_req1_valid = 1; a_req1_a = a; a_req1_b = b; end
    else     begin a_req0_valid = 1; a_req0_a = a; a_req0_b = b; end
    n = 0;
    @(negedge clk);
    while (!(idx ? a_req1_ready : a_req0_ready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) note_fail("a_accept_timeout", n, 0);
    @(posedge clk); #1;
    if (idx) a_req1_valid = 0; else a_req0_valid = 0;
  endtask

  // Counts edges from the current point until the response valid is seen.
  task automatic wait_rsp_a(input bit idx, output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!(idx ? a_rsp1_valid : a_rsp0_valid) && n < 40);
  endtask

  initial begin
    #200000;
    note_fail("global_timeout", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  bit [1:0] b_ops [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
  int       b_exp [5] = '{0, 2, 2, 1, 2};

  initial begin
    int n;
    rst = 0;
    a_req0_valid = 0; a_req0_a = 0; a_req0_b = 0;
    a_req1_valid = 0; a_req1_a = 0; a_req1_b = 0;
    a_rsp0_ready = 1; a_rsp1_ready = 1;
    b_req0_valid = 0; b_req0_a = 0; b_req0_b = 0;
    b_req1_valid = 0; b_req1_a = 0; b_req1_b = 0;
    b_rsp0_ready = 1; b_rsp1_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid,
                          a_rsp0_c, a_rsp0_d, a_rsp1_c, a_rsp1_d, a_ex_a, a_ex_b, a_busy}, 0);
    chk("reset_done_cnt", a_done_cnt, 0);
    @(posedge clk); #1 rst = 1;

    // Single request: req0 (1,0) -> c=1 d=0
    exp_gnt.push_back(0); q0.push_back(2'b10);
    issue_a(0, 1, 0);
    chk("single_ex_ab", {a_ex_a, a_ex_b}, 2'b10);
    chk("single_busy", a_busy, 1);
    wait_rsp_a(0, n);
    chk("single_latency", n, 2);
    @(posedge clk); #1;
    chk("single_done_cnt", a_done_cnt, 1);

    // Backpressure on rsp1 while req0 waits; rr=1 so req1 wins first.
    a_rsp1_ready = 0;
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    q1.push_back(2'b01); q0.push_back(2'b00);
    a_req0_valid = 1; a_req0_a = 0; a_req0_b = 0;
    a_req1_valid = 1; a_req1_a = 1; a_req1_b = 1;
    n = 0;
    @(negedge clk);
    while (!a_req1_ready && n < 50) begin @(negedge clk); n++; end
    chk("bp_rr_grant", {a_req0_ready, a_req1_ready}, 2'b01);
    @(posedge clk); #1 a_req1_valid = 0;
    wait_rsp_a(1, n);
    chk("bp_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {a_rsp1_valid, a_rsp1_c, a_rsp1_d, a_req0_ready, a_req1_ready, a_busy}, 6'b101001);
    end
    @(posedge clk); #1 a_rsp1_ready = 1;
    n = 0;
    @(negedge clk);
    while (!a_req0_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 a_req0_valid = 0;
    wait_rsp_a(0, n);
    chk("bp_req0_latency", n, 2);
    @(posedge clk); #1;
    chk("bp_done_cnt", a_done_cnt, 3);

    // Reset in WAIT: rr is 1 but a lone req0 is granted; the transaction is discarded.
    exp_gnt.push_back(0);
    issue_a(0, 1, 1);
    chk("wait_busy", a_busy, 1);
    #2 rst = 0;
    #1;
    chk("async_reset_outputs", {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid,
                                a_rsp0_c, a_rsp0_d, a_rsp1_c, a_rsp1_d, a_ex_a, a_ex_b, a_busy}, 0);
    chk("async_reset_done_cnt", a_done_cnt, 0);
    @(posedge clk); #1 rst = 1;

    // Both continuously valid: (0,1)->c1d0, (1,1)->c0d1; grants 0,1,0,1 from rr=0.
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    q0.push_back(2'b10); q0.push_back(2'b10);
    q1.push_back(2'b01); q1.push_back(2'b01);
    begin
      int base;
      base = n_acc;
      a_req0_valid = 1; a_req0_a = 0; a_req0_b = 1;
      a_req1_valid = 1; a_req1_a = 1; a_req1_b = 1;
      n = 0;
      while (n_acc < base + 4 && n < 100) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      a_req0_valid = 0; a_req1_valid = 0;
      chk("alt_accepts", n_acc - base, 4);
    end
    chk("alt_spacing", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 4);
    repeat (8) @(posedge clk);
    #1;
    chk("alt_done_cnt", a_done_cnt, 4);
    chk("a_queues_drained", q0.size() + q1.size() + exp_gnt.size(), 0);

    // Instance B: latency 4, done_cnt wraps modulo 4.
    for (int i = 0; i < 5; i++) begin
      bq0.push_back(b_exp[i]);
      @(posedge clk); #1;
      b_req0_valid = 1; b_req0_a = b_ops[i][1]; b_req0_b = b_ops[i][0];
      n = 0;
      @(negedge clk);
      while (!b_req0_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1 b_req0_valid = 0;
      n = 0;
      do begin @(posedge clk); n++; #1; end while (!b_rsp0_valid && n < 40);
      chk("b_latency", n, 4);
      @(posedge clk); #1;
      chk("b_done_cnt", b_done_cnt, (i + 1) % 4);
    end
    chk("b_queue_drained", bq0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
